// File: rtl/mmss_counter_if.sv
// Control/display bundle for the mm:ss stopwatch counter.
// master drives the controls and reads the display; slave is the counter.
interface mmss_counter_if;
    logic       start;
    logic       clear;
    logic       lap;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic       running;
    logic       wrap;

    modport master (
        output start, clear, lap,
        input  seconds, minutes, running, wrap
    );

    modport slave (
        input  start, clear, lap,
        output seconds, minutes, running, wrap
    );
endinterface

// File: rtl/mmss_counter.sv
// Minutes:seconds stopwatch with run/pause/clear control and a one-second prescaler.
// Optional lap-freeze of the displayed value is enabled by defining LAP_FREEZE_EN.
module mmss_counter #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned MAX_MIN  = 59
) (
    input  logic            clk,
    input  logic            reset_n,
    mmss_counter_if.slave   bus
);

    localparam int unsigned PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW       = 6;
    localparam logic [CW-1:0] SEC_TOP = CW'(59);
    localparam logic [CW-1:0] MIN_TOP = CW'(MAX_MIN);
    localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] sec_q,   sec_d;
    logic [CW-1:0] min_q,   min_d;
    logic          running_q, running_d;
    logic          wrap_q,    wrap_d;
    logic          tick_c;

`ifdef LAP_FREEZE_EN
    logic          frz_q,      frz_d;
    logic [CW-1:0] disp_sec_q, disp_sec_d;
    logic [CW-1:0] disp_min_q, disp_min_d;
`else
    logic          unused_lap;
    assign unused_lap = bus.lap;
`endif

    assign tick_c = (state_q == ST_RUN) && (presc_q == PRE_TOP);

    // Next-state: clear dominates; a tick and a start in the same cycle both take effect.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        sec_d     = sec_q;
        min_d     = min_q;
        wrap_d    = 1'b0;
`ifdef LAP_FREEZE_EN
        frz_d     = frz_q;
`endif
        if (bus.clear) begin
            state_d = ST_IDLE;
            presc_d = '0;
            sec_d   = '0;
            min_d   = '0;
`ifdef LAP_FREEZE_EN
            frz_d   = 1'b0;
`endif
        end else begin
            if (state_q == ST_RUN) begin
                presc_d = tick_c ? '0 : presc_q + PW'(1);
            end
            if (tick_c) begin
                if (sec_q < SEC_TOP) begin
                    sec_d = sec_q + CW'(1);
                end else if (min_q < MIN_TOP) begin
                    sec_d = '0;
                    min_d = min_q + CW'(1);
                end else begin
                    sec_d  = '0;
                    min_d  = '0;
                    wrap_d = 1'b1;
                end
            end
            if (bus.start) begin
                unique case (state_q)
                    ST_IDLE:  state_d = ST_RUN;
                    ST_RUN:   state_d = ST_PAUSE;
                    ST_PAUSE: state_d = ST_RUN;
                    default:  state_d = ST_IDLE;
                endcase
            end
`ifdef LAP_FREEZE_EN
            if (bus.lap && (state_q != ST_IDLE)) begin
                frz_d = ~frz_q;
            end
`endif
        end
        running_d = (state_d == ST_RUN);
    end

`ifdef LAP_FREEZE_EN
    // Display holds its last value while frozen, otherwise tracks the live count.
    always_comb begin
        disp_sec_d = sec_d;
        disp_min_d = min_d;
        if (frz_d) begin
            disp_sec_d = disp_sec_q;
            disp_min_d = disp_min_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            running_q  <= 1'b0;
            wrap_q     <= 1'b0;
`ifdef LAP_FREEZE_EN
            frz_q      <= 1'b0;
            disp_sec_q <= '0;
            disp_min_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            running_q  <= running_d;
            wrap_q     <= wrap_d;
`ifdef LAP_FREEZE_EN
            frz_q      <= frz_d;
            disp_sec_q <= disp_sec_d;
            disp_min_q <= disp_min_d;
`endif
        end
    end

`ifdef LAP_FREEZE_EN
    assign bus.seconds = disp_sec_q;
    assign bus.minutes = disp_min_q;
`else
    assign bus.seconds = sec_q;
    assign bus.minutes = min_q;
`endif
    assign bus.running = running_q;
    assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_mmss_counter.sv
// Self-checking bench for mmss_counter: directed scenarios plus random control traffic,
// every cycle compared against an elapsed-seconds reference model.
module tb_mmss_counter;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned MAX_MIN  = 1;
    localparam int          SPAN     = (MAX_MIN + 1) * 60;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fails;

    mmss_counter_if bus_if ();

    mmss_counter #(.TICK_DIV(TICK_DIV), .MAX_MIN(MAX_MIN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode, prescaler phase and total elapsed seconds in the wrap span.
    int m_mode;   // 0 idle, 1 run, 2 pause
    int m_pre;
    int m_tot;
    bit m_wrap;
    bit m_frz;
    int m_ftot;

    task automatic model_reset();
        m_mode = 0; m_pre = 0; m_tot = 0; m_wrap = 0; m_frz = 0; m_ftot = 0;
    endtask

    task automatic model_step(input bit s, input bit c, input bit l);
        bit tick;
        if (c) begin
            model_reset();
        end else begin
            tick   = (m_mode == 1) && (m_pre == TICK_DIV - 1);
            m_wrap = tick && (m_tot == SPAN - 1);
`ifdef LAP_FREEZE_EN
            if (l && m_mode != 0) begin
                if (m_frz) m_frz = 0;
                else begin m_frz = 1; m_ftot = m_tot; end
            end
`else
            if (l) m_ftot = m_ftot;
`endif
            if (m_mode == 1) m_pre = (m_pre + 1) % TICK_DIV;
            if (tick) m_tot = (m_tot + 1) % SPAN;
            if (s) m_mode = (m_mode == 1) ? 2 : 1;
        end
    endtask

    function automatic logic [31:0] model_out();
        int disp;
        disp = m_frz ? m_ftot : m_tot;
        return 32'({(m_mode == 1), m_wrap, 6'(disp / 60), 6'(disp % 60)});
    endfunction

    function automatic logic [31:0] dut_out();
        return 32'({bus_if.running, bus_if.wrap, bus_if.minutes, bus_if.seconds});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive controls, advance model at the edge, compare just after it.
    task automatic cycle(input bit s, input bit c, input bit l);
        bus_if.start = s;
        bus_if.clear = c;
        bus_if.lap   = l;
        @(posedge clk);
        model_step(s, c, l);
        #1;
        check("cycle", dut_out(), model_out());
    endtask

    function automatic logic [31:0] mmss();
        return 32'({bus_if.minutes, bus_if.seconds});
    endfunction

    initial begin
        int wraps;
        int n;
        n_checks = 0;
        n_fails  = 0;
        model_reset();
        reset_n      = 1'b0;
        bus_if.start = 1'b0;
        bus_if.clear = 1'b0;
        bus_if.lap   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_out(), 32'd0);
        reset_n = 1'b1;

        // Start and run one full minute.
        cycle(1, 0, 0);
        check("running_after_start", 32'(bus_if.running), 32'd1);
        repeat (240) cycle(0, 0, 0);
        check("one_minute", mmss(), 32'({6'd1, 6'd0}));

        // Continue to rollover: exactly one wrap pulse, ends at 00:00.
        wraps = 0;
        repeat (240) begin
            cycle(0, 0, 0);
            if (bus_if.wrap) wraps++;
        end
        check("wrap_count", 32'(wraps), 32'd1);
        check("after_wrap", mmss(), 32'd0);

        // Clear and start together at 00:30 go to idle.
        repeat (120) cycle(0, 0, 0);
        check("at_0030", mmss(), 32'({6'd0, 6'd30}));
        cycle(1, 1, 0);
        check("clear_beats_start", dut_out(), 32'd0);

        // Pause at 00:05 with prescaler at 2, hold, resume: tick two cycles later.
        cycle(1, 0, 0);
        repeat (21) cycle(0, 0, 0);
        cycle(1, 0, 0);
        check("paused", 32'({bus_if.running, bus_if.minutes, bus_if.seconds}), 32'({1'b0, 6'd0, 6'd5}));
        repeat (100) cycle(0, 0, 0);
        check("pause_hold", mmss(), 32'({6'd0, 6'd5}));
        cycle(1, 0, 0);
        n = 0;
        while (bus_if.seconds == 6'd5 && n < 10) begin
            cycle(0, 0, 0);
            n++;
        end
        check("resume_tick_delay", 32'(n), 32'd2);

        // Asynchronous reset mid-prescale at 00:17.
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        repeat (17 * 4 + 2) cycle(0, 0, 0);
        check("at_0017", mmss(), 32'({6'd0, 6'd17}));
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_reset", dut_out(), 32'd0);
        @(posedge clk);
        #1;
        check("reset_held", dut_out(), 32'd0);
        reset_n = 1'b1;

        // Lap at 00:10, run 20 ticks, lap again.
        cycle(1, 0, 0);
        repeat (40) cycle(0, 0, 0);
        cycle(0, 0, 1);
        repeat (80) cycle(0, 0, 0);
`ifdef LAP_FREEZE_EN
        check("lap_frozen", mmss(), 32'({6'd0, 6'd10}));
`else
        check("lap_ignored", mmss(), 32'({6'd0, 6'd30}));
`endif
        cycle(0, 0, 1);
        check("lap_release", mmss(), 32'({6'd0, 6'd30}));

        // Random control traffic.
        repeat (3000) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0,
                  $urandom_range(0, 49) == 0);
            check("range", 32'((bus_if.seconds <= 6'd59) && (bus_if.minutes <= 6'(MAX_MIN))), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
